shootout_round_ctrl: RTL



---
 rtl/shootout_pkg.sv | 30 +++
 rtl/shootout_round_ctrl_tick_timer.sv | 41 ++++
 rtl/shootout_round_ctrl.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/shootout_pkg.sv
// Shared types and constants for the penalty-shootout round controller.
package shootout_pkg;

    localparam int GRID_MAX    = 15;
    localparam int KEEPER_HOME = 7;

    typedef enum logic [2:0] {
        IDLE,
        AIM,
        FLIGHT,
        RESOLVE,
        RESULT,
        DONE
    } state_e;

    typedef enum logic [1:0] {
        R_NONE,
        R_GOAL,
        R_SAVE,
        R_MISS
    } result_e;

    // Keeper covers x-1..x+1; compare as 5-bit signed so the difference never wraps.
    function automatic logic keeper_covers(input logic [3:0] keeper_x, input logic [3:0] ball_x);
        logic signed [4:0] diff;
        diff = $signed({1'b0, keeper_x}) - $signed({1'b0, ball_x});
        return (diff >= -5'sd1) && (diff <= 5'sd1);
    endfunction

endpackage

// File: rtl/shootout_round_ctrl_tick_timer.sv
// Free-running N-cycle tick counter with clear/enable and a terminal-count strobe.
module tick_timer #(
    parameter int N = 4
) (
    input  logic clk,
    input  logic RST,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    localparam int            W    = (N > 1) ? $clog2(N) : 1;
    localparam logic [W-1:0]  LAST = W'(N - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: clear wins, otherwise wrap at the terminal value while enabled.
    always_comb begin
        // NOTE: default assignment first so no path through this block leaves cnt_d unassigned (no latch).
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    assign tc_o = en_i && !clr_i && (cnt_q == LAST);

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignment for state so every flop samples pre-edge values.
        if (RST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/shootout_round_ctrl.sv
// Five-shot penalty shootout sequencer: aim, ball flight, resolve, result hold.
module shootout_round_ctrl
    import shootout_pkg::*;
#(
    parameter int MAX_SHOTS    = 5,
    parameter int FLIGHT_TICKS = 4,
    parameter int HOLD_TICKS   = 8,
    parameter int START_X      = 7,
    parameter int START_Y      = 13,
    parameter int GOAL_ROW     = 1,
    parameter int POST_L       = 4,
    parameter int POST_R       = 11
) (
    input  logic       clk,
    input  logic       RST,
    input  logic       start,
    input  logic       left,
    input  logic       right,
    input  logic       shoot,
    input  logic       defense,
    output logic [3:0] player_x,
    output logic [3:0] player_y,
    output logic [3:0] goalkeeper_x,
    output logic [2:0] score,
    output logic [2:0] shots_num,
    output logic [1:0] result,
    output logic       game_over,
    output logic       active
);

    localparam logic [3:0] START_X4   = 4'(START_X);
    localparam logic [3:0] START_Y4   = 4'(START_Y);
    localparam logic [3:0] LAST_STEP  = 4'(GOAL_ROW + 1);
    localparam logic [3:0] POST_L4    = 4'(POST_L);
    localparam logic [3:0] POST_R4    = 4'(POST_R);
    localparam logic [3:0] GRID_MAX4  = 4'(GRID_MAX);
    localparam logic [3:0] KEEPER4    = 4'(KEEPER_HOME);
    localparam logic [2:0] MAX_SHOTS3 = 3'(MAX_SHOTS);

    state_e     state_q,  state_d;
    result_e    result_q, result_d;
    logic [3:0] px_q,     px_d;
    logic [3:0] py_q,     py_d;
    logic [3:0] gk_q,     gk_d;
    logic [2:0] score_q,  score_d;
    logic [2:0] shots_q,  shots_d;
    logic       dive_q,   dive_d;

    logic flight_en, flight_tc;
    logic hold_en,   hold_tc;

    assign flight_en = (state_q == FLIGHT);
    assign hold_en   = (state_q == RESULT);

    tick_timer #(.N(FLIGHT_TICKS)) u_flight_timer (
        .clk   (clk),
        .RST   (RST),
        .clr_i (!flight_en),
        .en_i  (flight_en),
        .tc_o  (flight_tc)
    );

    tick_timer #(.N(HOLD_TICKS)) u_hold_timer (
        .clk   (clk),
        .RST   (RST),
        .clr_i (!hold_en),
        .en_i  (hold_en),
        .tc_o  (hold_tc)
    );

    // Next-state and datapath updates for the round sequencer.
    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        px_d     = px_q;
        py_d     = py_q;
        gk_d     = gk_q;
        score_d  = score_q;
        shots_d  = shots_q;
        dive_d   = dive_q;

        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d  = AIM;
                    score_d  = '0;
                    shots_d  = '0;
                    result_d = R_NONE;
                    px_d     = START_X4;
                    py_d     = START_Y4;
                    gk_d     = KEEPER4;
                    dive_d   = 1'b0;
                end
            end

            AIM: begin
                if (shoot) begin
                    dive_d  = defense;
                    state_d = FLIGHT;
                end else if (left && !right) begin
                    if (px_q != 4'd0) px_d = px_q - 4'd1;
                end else if (right && !left) begin
                    if (px_q != GRID_MAX4) px_d = px_q + 4'd1;
                end
            end

            FLIGHT: begin
                if (flight_tc) begin
                    py_d = py_q - 4'd1;
                    if (dive_q && (gk_q != px_q)) begin
                        gk_d = (gk_q < px_q) ? gk_q + 4'd1 : gk_q - 4'd1;
                    end
                    if (py_q == LAST_STEP) state_d = RESOLVE;
                end
            end

            RESOLVE: begin
                shots_d = shots_q + 3'd1;
                if ((px_q < POST_L4) || (px_q > POST_R4)) begin
                    result_d = R_MISS;
                end else if (keeper_covers(gk_q, px_q)) begin
                    result_d = R_SAVE;
                end else begin
                    result_d = R_GOAL;
                    score_d  = score_q + 3'd1;
                end
                state_d = RESULT;
            end

            RESULT: begin
                if (hold_tc) begin
                    if (shots_q == MAX_SHOTS3) begin
                        state_d = DONE;
                    end else begin
                        state_d  = AIM;
                        result_d = R_NONE;
                        px_d     = START_X4;
                        py_d     = START_Y4;
                        gk_d     = KEEPER4;
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (RST) begin
            state_q  <= IDLE;
            result_q <= R_NONE;
            px_q     <= START_X4;
            py_q     <= START_Y4;
            gk_q     <= KEEPER4;
            score_q  <= '0;
            shots_q  <= '0;
            dive_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            px_q     <= px_d;
            py_q     <= py_d;
            gk_q     <= gk_d;
            score_q  <= score_d;
            shots_q  <= shots_d;
            dive_q   <= dive_d;
        end
    end

    assign player_x     = px_q;
    assign player_y     = py_q;
    assign goalkeeper_x = gk_q;
    assign score        = score_q;
    assign shots_num    = shots_q;
    assign result       = result_q;
    assign game_over    = (state_q == DONE);
    assign active       = (state_q == AIM) || (state_q == FLIGHT) ||
                          (state_q == RESOLVE) || (state_q == RESULT);

endmodule
